// File: rtl/conv_pkg.sv
// Shared constants and state type for the convolution-engine feeder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package conv_pkg;

    localparam int DATA_W      = 16;
    localparam int KERN_N      = 9;
    localparam int PIX_N       = 49;
    localparam int RES_N       = 25;
    localparam int FRAME_N     = KERN_N + PIX_N;
    localparam int TIMEOUT_DEF = 255;

    // Index width covers 0..FRAME_N, count width covers 0..RES_N.
    localparam int IDX_W = 6;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } feed_state_t;

endpackage

// File: rtl/conv_word_buf.sv
// Depth x width register file: one synchronous write port, one combinational read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; out-of-range writes are dropped and out-of-range reads return zero.
module conv_word_buf #(
    parameter int DEPTH = 58,
    parameter int WIDTH = 16,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    localparam logic [AW:0] LIMIT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (we && ({1'b0, waddr} < LIMIT)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = ({1'b0, raddr} < LIMIT) ? mem[raddr] : '0;

endmodule

// File: rtl/conv_stream_feeder.sv
// Buffers a kernel+picture frame, streams it to the conv engine as one 58-cycle burst, collects results.
// Latency: first word on con_data the cycle after start; done at least 60 cycles after start.
// Backpressure: none; burst is never stalled, results beyond RES_N and host inputs while busy are dropped.
module conv_stream_feeder
    import conv_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  res_cnt,
    output logic              con_ena,
    output logic [DATA_W-1:0] con_data,
    input  logic              res_valid,
    input  logic              res_finish,
    input  logic [DATA_W-1:0] res_data,
    input  logic [CNT_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int               TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(FRAME_N);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RES_N);

    feed_state_t       state;
    feed_state_t       state_nxt;
    logic [IDX_W-1:0]  idx;       // next word to present during SEND
    logic [TMO_W-1:0]  tmo;
    logic [IDX_W-1:0]  in_raddr;
    logic [DATA_W-1:0] in_rdata;
    logic              launch;
    logic              in_we;
    logic              capture;

    assign launch  = (state == IDLE) && start;
    assign in_we   = (state == IDLE) && wr_en && (wr_addr < IDX_END);
    assign capture = ((state == SEND) || (state == WAIT)) && res_valid && (res_cnt < CNT_FULL);

    // In IDLE the read port sits on word 0 so the launch edge can register it directly.
    assign in_raddr = (state == SEND) ? idx : '0;

    conv_word_buf #(
        .DEPTH (FRAME_N),
        .WIDTH (DATA_W),
        .AW    (IDX_W)
    ) in_buf (
        .clk   (clk),
        .we    (in_we),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (in_raddr),
        .rdata (in_rdata)
    );

    conv_word_buf #(
        .DEPTH (RES_N),
        .WIDTH (DATA_W),
        .AW    (CNT_W)
    ) res_buf (
        .clk   (clk),
        .we    (capture),
        .waddr (res_cnt),
        .wdata (res_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: SEND runs to the last word unconditionally, WAIT leaves on the first exit cause.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (launch) state_nxt = SEND;
            SEND: if (idx == IDX_END) state_nxt = WAIT;
            WAIT: if (res_finish || (res_cnt == CNT_FULL) || (tmo == TMO_MAX)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame counters, result count and sticky timeout flag; all restart on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            tmo     <= '0;
            res_cnt <= '0;
            err     <= 1'b0;
        end else if (launch) begin
            idx     <= IDX_W'(1);
            tmo     <= '0;
            res_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (state == SEND) begin
                idx <= idx + 1'b1;
            end
            if (state == WAIT) begin
                tmo <= res_valid ? '0 : tmo + 1'b1;
            end
            if (capture) begin
                res_cnt <= res_cnt + 1'b1;
            end
            if ((state == WAIT) && (tmo == TMO_MAX)) begin
                err <= 1'b1;
            end
        end
    end

    // Registered outputs derived from the state being entered, so they align with the new state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            con_ena  <= 1'b0;
            con_data <= '0;
        end else begin
            busy     <= (state_nxt != IDLE);
            done     <= (state_nxt == DONE);
            con_ena  <= (state_nxt == SEND);
            con_data <= (state_nxt == SEND) ? in_rdata : '0;
        end
    end

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Self-checking bench for conv_stream_feeder: frame-level reference model plus directed and random frames.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_conv_stream_feeder;
    import conv_pkg::*;

    localparam int MODE_NORMAL = 0;
    localparam int MODE_TMO    = 1;
    localparam int MODE_OVF    = 2;
    localparam int MODE_RAND   = 3;
    localparam int MODE_FIN0   = 4;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic [4:0]  res_cnt;
    logic        con_ena;
    logic [15:0] con_data;
    logic        res_valid;
    logic        res_finish;
    logic [15:0] res_data;
    logic [4:0]  rd_addr;
    logic [15:0] rd_data;

    conv_stream_feeder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .res_cnt    (res_cnt),
        .con_ena    (con_ena),
        .con_data   (con_data),
        .res_valid  (res_valid),
        .res_finish (res_finish),
        .res_data   (res_data),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Reference model: frame timeline measured in cycles since the accepted start.
    logic [15:0] m_in  [58];
    logic [15:0] m_res [25];
    bit          m_known [25];
    bit          m_active;
    bit          m_done;
    bit          m_err;
    int          m_t;
    int          m_cnt;
    int          m_tmo;

    int checks;
    int failures;
    int cyc;

    int s_mode;
    int s_n;
    bit s_go;
    int s_p;
    int s_f;

    int r_ena;
    int r_first;
    int r_last;
    int r_dist;
    logic r_first_ena;
    logic r_first_err;
    logic [4:0] r_first_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_done   = 1'b0;
        m_err    = 1'b0;
        m_t      = 0;
        m_cnt    = 0;
        m_tmo    = 0;
    endtask

    // Advance the model by one clock edge using the inputs held during the cycle that just ended.
    task automatic model_update();
        bit waiting;
        bit leave;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (!m_active) begin
            if (wr_en && (wr_addr < 6'd58)) m_in[wr_addr] = wr_data;
            if (start) begin
                m_active = 1'b1;
                m_done   = 1'b0;
                m_t      = 1;
                m_cnt    = 0;
                m_err    = 1'b0;
                m_tmo    = 0;
            end
        end else if (m_done) begin
            m_active = 1'b0;
            m_done   = 1'b0;
        end else begin
            waiting = (m_t > FRAME_N);
            leave   = waiting && (res_finish || (m_cnt == RES_N) || (m_tmo == 255));
            if (waiting && (m_tmo == 255)) m_err = 1'b1;
            if (waiting) m_tmo = res_valid ? 0 : m_tmo + 1;
            if (res_valid && (m_cnt < RES_N)) begin
                m_res[m_cnt]   = res_data;
                m_known[m_cnt] = 1'b1;
                m_cnt++;
            end
            if (leave) m_done = 1'b1;
            else       m_t++;
        end
    endtask

    task automatic compare();
        bit          exp_ena;
        logic [15:0] exp_dat;
        exp_ena = m_active && !m_done && (m_t <= FRAME_N);
        exp_dat = exp_ena ? m_in[m_t-1] : 16'd0;
        chk("busy", busy, m_active);
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("res_cnt", res_cnt, m_cnt);
        chk("con_ena", con_ena, exp_ena);
        chk("con_data", con_data, exp_dat);
        if (rd_addr >= 5'd25) chk("rd_data_oob", rd_data, 0);
        else if (m_known[rd_addr]) chk("rd_data", rd_data, m_res[rd_addr]);
    endtask

    // Engine stub: decides result strobes for the current cycle from the frame timeline.
    task automatic stub_drive();
        bit live;
        bit waiting;
        live    = m_active && !m_done;
        waiting = live && (m_t > FRAME_N);
        res_valid  = 1'b0;
        res_finish = 1'b0;
        res_data   = 16'($urandom);
        case (s_mode)
            MODE_NORMAL: begin
                if (waiting) begin
                    if (s_n < 25) begin
                        res_valid = 1'b1;
                        res_data  = 16'(100 + s_n);
                        s_n++;
                    end else begin
                        res_finish = 1'b1;
                    end
                end
            end
            MODE_OVF: begin
                if (waiting) s_go = 1'b1;
                if (s_go && (s_n < 30)) begin
                    res_valid = 1'b1;
                    res_data  = 16'(s_n);
                    s_n++;
                end
            end
            MODE_FIN0: begin
                if (waiting) res_finish = 1'b1;
            end
            MODE_RAND: begin
                res_valid = ($urandom_range(0, s_p - 1) == 0);
                if (waiting && ($urandom_range(0, s_f - 1) == 0)) res_finish = 1'b1;
            end
            default: ;
        endcase
        rd_addr = 5'($urandom_range(0, 31));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        cyc++;
        compare();
        stub_drive();
    endtask

    task automatic write_word(input int a, input logic [15:0] d);
        wr_en   = 1'b1;
        wr_addr = 6'(a);
        wr_data = d;
        cycle();
        wr_en   = 1'b0;
    endtask

    task automatic read_chk(input string name, input int a, input int exp);
        rd_addr = 5'(a);
        #1;
        chk(name, rd_data, exp);
    endtask

    // Launch a frame and run until done; inject>0 fires a start and a write of DEAD to word 0 that many cycles in.
    task automatic run_frame(input int mode, input int inject);
        int st;
        int fall;
        int dn;
        s_mode  = mode;
        s_n     = 0;
        s_go    = 1'b0;
        r_ena   = 0;
        r_first = -1;
        r_last  = -1;
        fall    = -1;
        dn      = -1;
        wr_en   = 1'b0;
        start   = 1'b1;
        st      = cyc;
        cycle();
        start       = 1'b0;
        r_first_ena = con_ena;
        r_first_err = err;
        r_first_cnt = res_cnt;
        for (int k = 0; k < 1000; k++) begin
            if (con_ena) begin
                if (r_ena == 0) r_first = int'(con_data);
                r_last = int'(con_data);
                r_ena++;
            end else if ((r_ena > 0) && (fall < 0)) begin
                fall = cyc;
            end
            if (done) begin
                dn = cyc;
                break;
            end
            start = 1'b0;
            wr_en = 1'b0;
            if ((inject > 0) && (cyc - st == inject)) begin
                start   = 1'b1;
                wr_en   = 1'b1;
                wr_addr = 6'd0;
                wr_data = 16'hDEAD;
            end
            cycle();
        end
        start = 1'b0;
        wr_en = 1'b0;
        if (dn < 0) chk("frame_done_seen", {31'd0, done}, 1);
        r_dist = dn - fall;
    endtask

    initial begin
        int relaunch;
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        s_mode     = MODE_TMO;
        s_n        = 0;
        s_go       = 1'b0;
        s_p        = 8;
        s_f        = 4;
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        start      = 1'b0;
        res_valid  = 1'b0;
        res_finish = 1'b0;
        res_data   = '0;
        rd_addr    = '0;
        for (int i = 0; i < 25; i++) m_known[i] = 1'b0;
        model_reset();

        // Reset state.
        repeat (3) cycle();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_con_ena", con_ena, 0);
        chk("rst_con_data", con_data, 0);
        chk("rst_res_cnt", res_cnt, 0);
        rst_n = 1'b1;
        repeat (2) cycle();

        // Load in_buf[i] = i+1, plus an ignored out-of-range write.
        for (int i = 0; i < 58; i++) write_word(i, 16'(i + 1));
        write_word(58, 16'hFFFF);
        write_word(63, 16'hFFFF);

        // Normal frame.
        run_frame(MODE_NORMAL, 0);
        chk("norm_ena_cycles", r_ena, 58);
        chk("norm_first_word", r_first, 1);
        chk("norm_last_word", r_last, 58);
        chk("norm_done_after_fall", r_dist, 26);
        chk("norm_res_cnt", res_cnt, 25);
        chk("norm_err", err, 0);
        read_chk("norm_rd4", 4, 104);
        read_chk("norm_rd24", 24, 124);
        repeat (3) cycle();

        // Start and write during SEND are ignored; immediate finish gives the shortest WAIT.
        run_frame(MODE_FIN0, 10);
        chk("ign_first_word", r_first, 1);
        chk("ign_ena_cycles", r_ena, 58);
        chk("min_done_after_fall", r_dist, 1);
        relaunch = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            relaunch += int'(busy);
        end
        chk("ign_no_relaunch", relaunch, 0);

        // Timeout frame.
        run_frame(MODE_TMO, 0);
        chk("tmo_done_after_fall", r_dist, 256);
        chk("tmo_err", err, 1);
        chk("tmo_res_cnt", res_cnt, 0);

        // Back-to-back: start in the cycle busy falls.
        cycle();
        chk("b2b_busy_low", busy, 0);
        run_frame(MODE_FIN0, 0);
        chk("b2b_con_ena_rises", r_first_ena, 1);
        chk("b2b_err_cleared", r_first_err, 0);
        chk("b2b_res_cnt_cleared", r_first_cnt, 0);
        chk("b2b_word0_kept", r_first, 1);
        repeat (2) cycle();

        // Overflow: 30 valids, only the first 25 stored.
        run_frame(MODE_OVF, 0);
        chk("ovf_done_after_fall", r_dist, 26);
        chk("ovf_res_cnt", res_cnt, 25);
        read_chk("ovf_rd0", 0, 0);
        read_chk("ovf_rd12", 12, 12);
        read_chk("ovf_rd24", 24, 24);
        read_chk("ovf_rd25", 25, 0);
        read_chk("ovf_rd31", 31, 0);
        repeat (6) cycle();

        // Asynchronous reset in the middle of SEND.
        s_mode = MODE_TMO;
        start  = 1'b1;
        cycle();
        start = 1'b0;
        repeat (20) cycle();
        rst_n = 1'b0;
        #1;
        chk("arst_con_ena", con_ena, 0);
        chk("arst_con_data", con_data, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_err", err, 0);
        chk("arst_res_cnt", res_cnt, 0);
        model_reset();
        repeat (2) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();
        run_frame(MODE_FIN0, 0);
        chk("post_rst_first_word", r_first, 1);
        chk("post_rst_last_word", r_last, 58);

        // Randomized frames with random buffer rewrites.
        for (int f = 0; f < 8; f++) begin
            s_mode = MODE_RAND;
            for (int w = 0; w < 6; w++) write_word($urandom_range(0, 63), 16'($urandom));
            s_p = (f % 3 == 0) ? 1 : ((f % 3 == 1) ? 2 : 8);
            s_f = (f == 5) ? 400 : 4;
            run_frame(MODE_RAND, 0);
            repeat ($urandom_range(0, 3)) cycle();
        end
        repeat (4) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_stream_feeder.md
# conv_stream_feeder

Host-side driver for the 3x3/7x7 serial convolution engine. It buffers one 9-word kernel and one 49-word picture written by the host, streams them to the engine as one contiguous 58-cycle `ena` burst, and collects the engine's `valid`-qualified results into a 25-entry result buffer. The host reads the buffer back randomly. The block sits between the host register/memory interface and the convolution engine, and is the transmitter/collector for that engine's serial input protocol.

## Interface
- `DATA_W`, 16: word width of kernel, pixel and result words.
- `KERN_N`, 9: kernel words per frame.
- `PIX_N`, 49: picture words per frame.
- `RES_N`, 25: result buffer depth.
- `TIMEOUT`, 255: idle cycles allowed in WAIT before abort.

Ports:
- `clk`  in  1  Single clock. All logic is on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `wr_en`  in  1  Host write strobe into the input buffer.
- `wr_addr`  in  6  Input buffer address. 0..8 is the kernel in row-major order; 9..57 is the picture in engine order.
- `wr_data`  in  DATA_W  Input buffer write data.
- `start`  in  1  Single-cycle pulse that launches one frame.
- `busy`  out  1  High from the cycle after an accepted `start` through the DONE state.
- `done`  out  1  One-cycle pulse when the frame ends.
- `err`  out  1  Sticky timeout flag. Cleared by the next accepted `start`.
- `res_cnt`  out  5  Number of results captured in the current frame.
- `con_ena`  out  1  Enable to the engine.
- `con_data`  out  DATA_W  Serial data to the engine.
- `res_valid`  in  1  Engine result strobe.
- `res_finish`  in  1  Engine end-of-frame indication.
- `res_data`  in  DATA_W  Engine result word.
- `rd_addr`  in  5  Host result read address.
- `rd_data`  out  DATA_W  `res_buf[rd_addr]`, combinational. Reads 0 if `rd_addr >= RES_N`.

## Operation
FSM states are IDLE, SEND, WAIT and DONE.

**IDLE**
- `con_ena` = 0.
- Host writes are accepted. Addresses of 58 or above are ignored.
- `start` moves the FSM to SEND. On the same edge it clears `idx`, `res_cnt`, the timeout counter and `err`.

**SEND**
- Each cycle: `con_ena` = 1, `con_data` = `in_buf[idx]`, `idx` increments.
- After the word with `idx` = 57 has been driven, the FSM moves to WAIT. `con_ena` is low in the following cycle.
- The burst is never interrupted. `con_ena` must not drop mid-frame, because the engine restarts on low `ena`.

**Result capture (SEND and WAIT)**
- When `res_valid` = 1 and `res_cnt < RES_N`: `res_buf[res_cnt] <= res_data` and `res_cnt` increments.
- Valids received once `res_cnt = RES_N` are discarded.

**WAIT**
- The timeout counter increments on every cycle without `res_valid` and clears on `res_valid`.
- Exit to DONE on whichever of these occurs first:
  - `res_finish` = 1;
  - `res_cnt` reaches `RES_N`;
  - the timeout counter reaches `TIMEOUT`, which also sets `err` = 1.

**DONE**
- `done` = 1 for exactly one cycle, then the FSM returns to IDLE.

**Ignored inputs**
- `start` is ignored outside IDLE.
- `wr_en` is ignored outside IDLE, so the buffer is frozen during a frame.

**Reset (any state, including mid-SEND)**
- Outputs: `con_ena` = 0, `con_data` = 0, `busy` = 0, `done` = 0, `err` = 0, `res_cnt` = 0.
- FSM returns to IDLE.
- `in_buf` and `res_buf` contents are not reset.

## Timing
- All outputs except `rd_data` are registered.
- `start` sampled at edge N: `busy` = 1 and `con_ena` = 1 with `in_buf[0]` from edge N+1.
- `con_ena` stays high for cycles N+1..N+58. Word k is presented in cycle N+1+k.
- `res_valid` in cycle M: the word is stored and `res_cnt` updates at edge M+1. A valid in the same cycle as a finish or timeout exit is still captured.
- If `res_finish` and `res_valid` coincide in WAIT, the result is captured and the FSM goes to DONE.
- Minimum frame length is 60 cycles, `start` to `done` inclusive.
- `busy` falls in the cycle after `done`. A `start` in that cycle is accepted.

## Structure
- Shared package `conv_pkg` holds:
  - `DATA_W`, `KERN_N`, `PIX_N`, `RES_N`;
  - `FRAME_N` = `KERN_N + PIX_N` = 58;
  - the state enum `feed_state_t` (IDLE, SEND, WAIT, DONE).
- One sub-module, `conv_word_buf`: a parameterised depth x width register file with a synchronous write port and a combinational read port. It is instantiated twice: `in_buf` (depth 58) and `res_buf` (depth `RES_N`).
- The FSM, counters and capture logic live in the top.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-run → `con_ena` = `busy` = `done` = `err` = 0 and `res_cnt` = 0, asynchronously.
- **Normal frame:** load `in_buf[i] = i+1`, pulse `start`; the engine stub returns 25 valids with data 100..124, then `res_finish` → `con_data` sequence 1..58 over exactly 58 cycles; `done` pulses once; `res_cnt` = 25; `rd_data[4]` = 104; `err` = 0.
- **Timeout:** stub never asserts `res_valid` → `done` and `err` = 1 exactly 256 cycles after `con_ena` falls (`TIMEOUT` = 255); `res_cnt` = 0.
- **Overflow:** stub issues 30 valids (data 0..29) without `res_finish` → buffer holds 0..24; `done` follows the 25th capture; the extra valids are dropped.
- **Ignored inputs while busy:** `start` and a write of 16'hDEAD to address 0 during SEND → the frame is unchanged; after `done`, `in_buf[0]` still holds its old value and no second frame launches.
- **Back-to-back frames:** `start` in the cycle after `busy` falls → `con_ena` rises on the next cycle; `res_cnt` and `err` restart from 0.
